// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// Decode-and-issue stage in front of the ALU. Accepts RV32I OP / OP-IMM
// instructions with their source register values, maps funct3/funct7 onto
// the ALU opcode, selects the register or immediate second operand, and
// presents the result from a registered two-entry skid buffer.
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   in_valid       upstream presents an instruction
//   in_ready       stage can accept (registered, = skid entry empty)
//   in_instr       raw instruction word
//   in_rs1_data    rs1 value
//   in_rs2_data    rs2 value
//   out_valid      decoded request available
//   out_ready      execute stage accepts
//   out_alu_op     ALU opcode
//   out_operand_0  ALU operand_0
//   out_operand_1  ALU operand_1
//   out_rd         destination register
//   out_illegal    instruction not decodable here (issued as an ADD 0,0 token)
// -----------------------------------------------------------------------------
module alu_issue_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_rs1_data,
   input  logic [31:0] in_rs2_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [5:0]  out_alu_op,
   output logic [31:0] out_operand_0,
   output logic [31:0] out_operand_1,
   output logic [4:0]  out_rd,
   output logic        out_illegal
);

   localparam logic [5:0] ALU_ADD = 6'd0;
   localparam logic [5:0] ALU_SUB = 6'd1;
   localparam logic [5:0] ALU_AND = 6'd2;
   localparam logic [5:0] ALU_OR  = 6'd3;
   localparam logic [5:0] ALU_XOR = 6'd4;
   localparam logic [5:0] ALU_SLL = 6'd6;
   localparam logic [5:0] ALU_SRL = 6'd7;
   localparam logic [5:0] ALU_SRA = 6'd8;
   localparam logic [5:0] ALU_SLT = 6'd9;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] F7_ZERO    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   // ---------------------------------------------------------------------
   // Combinational decode of the incoming instruction
   // ---------------------------------------------------------------------
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        is_op;
   logic        is_imm;
   logic        is_shift;
   logic        legal;
   logic [5:0]  dec_op;
   logic [31:0] dec_op0;
   logic [31:0] dec_op1;
   logic [4:0]  dec_rd;
   logic        dec_ill;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];
   assign is_op  = (opcode == OPC_OP);
   assign is_imm = (opcode == OPC_OP_IMM);

   always_comb begin
      dec_op   = ALU_ADD;
      legal    = 1'b0;
      is_shift = 1'b0;
      case (funct3)
         3'b000: begin
            if (is_imm) begin
               dec_op = ALU_ADD;
               legal  = 1'b1;
            end else if (funct7 == F7_ZERO) begin
               dec_op = ALU_ADD;
               legal  = 1'b1;
            end else if (funct7 == F7_ALT) begin
               dec_op = ALU_SUB;
               legal  = 1'b1;
            end
         end
         3'b111: begin
            dec_op = ALU_AND;
            legal  = is_imm || (funct7 == F7_ZERO);
         end
         3'b110: begin
            dec_op = ALU_OR;
            legal  = is_imm || (funct7 == F7_ZERO);
         end
         3'b100: begin
            dec_op = ALU_XOR;
            legal  = is_imm || (funct7 == F7_ZERO);
         end
         3'b010: begin
            dec_op = ALU_SLT;
            legal  = is_imm || (funct7 == F7_ZERO);
         end
         3'b001: begin
            dec_op   = ALU_SLL;
            is_shift = 1'b1;
            legal    = (funct7 == F7_ZERO);
         end
         3'b101: begin
            is_shift = 1'b1;
            if (funct7 == F7_ZERO) begin
               dec_op = ALU_SRL;
               legal  = 1'b1;
            end else if (funct7 == F7_ALT) begin
               dec_op = ALU_SRA;
               legal  = 1'b1;
            end
         end
         default: legal = 1'b0;   // 011 (SLTU) is not handled here
      endcase

      // Major opcode gates everything; illegal tokens carry ADD 0,0 -> x0.
      dec_ill = !(legal && (is_op || is_imm));
      if (dec_ill) begin
         dec_op  = ALU_ADD;
         dec_op0 = 32'd0;
         dec_op1 = 32'd0;
         dec_rd  = 5'd0;
      end else begin
         dec_op0 = in_rs1_data;
         dec_rd  = in_instr[11:7];
         if (is_op)
            dec_op1 = in_rs2_data;
         else if (is_shift)
            dec_op1 = {27'd0, in_instr[24:20]};
         else
            dec_op1 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
   end

   // ---------------------------------------------------------------------
   // Two-entry skid buffer: main register drives the outputs, skid holds
   // the entry accepted while main was stalled.
   // ---------------------------------------------------------------------
   logic        skid_valid;
   logic [5:0]  skid_op;
   logic [31:0] skid_op0;
   logic [31:0] skid_op1;
   logic [4:0]  skid_rd;
   logic        skid_ill;
   logic        accept;
   logic        drain;

   assign accept = in_valid && in_ready;
   assign drain  = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready      <= 1'b1;
         out_valid     <= 1'b0;
         out_alu_op    <= 6'd0;
         out_operand_0 <= 32'd0;
         out_operand_1 <= 32'd0;
         out_rd        <= 5'd0;
         out_illegal   <= 1'b0;
         skid_valid    <= 1'b0;
         skid_op       <= 6'd0;
         skid_op0      <= 32'd0;
         skid_op1      <= 32'd0;
         skid_rd       <= 5'd0;
         skid_ill      <= 1'b0;
      end else if (!out_valid || drain) begin
         // Main is free this cycle; the skid entry (older) has priority.
         if (skid_valid) begin
            out_valid     <= 1'b1;
            out_alu_op    <= skid_op;
            out_operand_0 <= skid_op0;
            out_operand_1 <= skid_op1;
            out_rd        <= skid_rd;
            out_illegal   <= skid_ill;
            skid_valid    <= 1'b0;
            in_ready      <= 1'b1;
         end else if (accept) begin
            out_valid     <= 1'b1;
            out_alu_op    <= dec_op;
            out_operand_0 <= dec_op0;
            out_operand_1 <= dec_op1;
            out_rd        <= dec_rd;
            out_illegal   <= dec_ill;
         end else begin
            out_valid     <= 1'b0;
         end
      end else if (accept) begin
         // Main is stalled: park the new entry in skid and close the input.
         skid_valid <= 1'b1;
         skid_op    <= dec_op;
         skid_op0   <= dec_op0;
         skid_op1   <= dec_op1;
         skid_rd    <= dec_rd;
         skid_ill   <= dec_ill;
         in_ready   <= 1'b0;
      end
   end

endmodule
